fft_input_reorder: RTL and testbench

- Upstream neighbour of the radix-4 butterfly in the 16-point FFT datapath.
- Accepts a serial stream of complex samples x[0..15], one per handshake.
- Buffers each 16-sample frame in a ping-pong store and emits four groups of four complex operands per frame, in the first-stage butterfly order, ready to drive the butterfly A/B/C/D inputs.
- Double buffering allows one frame to fill while the previous one drains, so back-to-back frames run without stalls.

---
 rtl/fft_pkg.sv | 15 +
 rtl/fft_frame_bank.sv | 30 +++
 rtl/fft_input_reorder.sv | 114 +++++++++++
 tb/tb_fft_input_reorder.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared types and sizing for the 16-point radix-4 FFT datapath.
// Frame length and radix are fixed; DW_DEFAULT sets the complex component width.
package fft_pkg;
  localparam int DW_DEFAULT = 16;
  localparam int N_POINTS   = 16;
  localparam int RADIX      = 4;
  localparam int GROUPS     = N_POINTS / RADIX;
  localparam int AW         = $clog2(N_POINTS);
  localparam int GW         = $clog2(GROUPS);

  typedef struct packed {
    logic signed [DW_DEFAULT-1:0] re;
    logic signed [DW_DEFAULT-1:0] im;
  } cplx_t;
endpackage

// File: rtl/fft_frame_bank.sv
// One 16-entry complex frame store with a single write port.
// Four combinational taps present x[g], x[g+4], x[g+8], x[g+12] for group g.
module fft_frame_bank
  import fft_pkg::*;
(
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  cplx_t         wdat,
  input  logic [GW-1:0] grp,
  output cplx_t         tap_a,
  output cplx_t         tap_b,
  output cplx_t         tap_c,
  output cplx_t         tap_d
);

  // Contents are don't-care after reset, so the store carries no reset.
  cplx_t mem [N_POINTS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdat;
  end

  // The upper two index bits select the quarter of the frame, grp the offset within it.
  assign tap_a = mem[{2'd0, grp}];
  assign tap_b = mem[{2'd1, grp}];
  assign tap_c = mem[{2'd2, grp}];
  assign tap_d = mem[{2'd3, grp}];

endmodule

// File: rtl/fft_input_reorder.sv
// Ping-pong frame buffer feeding the first radix-4 butterfly stage; group 0 valid the cycle after sample 15.
// in_ready depends only on registered full flags; out_ready low holds all outputs stable.
module fft_input_reorder
  import fft_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_re,
  input  logic signed [DW-1:0] in_im,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] ar,
  output logic signed [DW-1:0] br,
  output logic signed [DW-1:0] cr,
  output logic signed [DW-1:0] dr,
  output logic signed [DW-1:0] ai,
  output logic signed [DW-1:0] bi,
  output logic signed [DW-1:0] ci,
  output logic signed [DW-1:0] di,
  output logic [1:0]           out_group,
  output logic                 out_last,
  output logic                 frame_err
);

  logic [AW-1:0] wr_cnt;
  logic [GW-1:0] rd_grp;
  logic          wr_bank;
  logic          rd_bank;
  logic [1:0]    full;
  logic          acc;
  logic          xfer;
  logic          wr_done;
  logic          rd_done;
  cplx_t         wdat;
  cplx_t         tap [2][4];

  assign in_ready  = !rst && !full[wr_bank];
  assign out_valid = full[rd_bank];
  assign acc       = in_valid && in_ready;
  assign xfer      = out_valid && out_ready;
  assign wr_done   = acc && (wr_cnt == AW'(N_POINTS - 1));
  assign rd_done   = xfer && (rd_grp == GW'(GROUPS - 1));
  assign wdat      = '{re: in_re, im: in_im};

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fft_frame_bank u_bank (
      .clk   (clk),
      .we    (acc && (wr_bank == 1'(b))),
      .waddr (wr_cnt),
      .wdat  (wdat),
      .grp   (rd_grp),
      .tap_a (tap[b][0]),
      .tap_b (tap[b][1]),
      .tap_c (tap[b][2]),
      .tap_d (tap[b][3])
    );
  end

  // Counters wrap naturally at their width, so no explicit wrap logic is needed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt    <= '0;
      rd_grp    <= '0;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      full      <= '0;
      frame_err <= 1'b0;
    end else begin
      if (acc) begin
        wr_cnt <= wr_cnt + 1'b1;
        if (in_last != (wr_cnt == AW'(N_POINTS - 1))) frame_err <= 1'b1;
      end
      if (wr_done) wr_bank <= !wr_bank;
      if (xfer) rd_grp <= rd_grp + 1'b1;
      if (rd_done) rd_bank <= !rd_bank;
      // A bank being filled is never the bank being drained, so set and clear never collide.
      for (int b = 0; b < 2; b++) begin
        if (wr_done && (wr_bank == 1'(b))) full[b] <= 1'b1;
        else if (rd_done && (rd_bank == 1'(b))) full[b] <= 1'b0;
      end
    end
  end

  always_comb begin
    ar        = '0;
    br        = '0;
    cr        = '0;
    dr        = '0;
    ai        = '0;
    bi        = '0;
    ci        = '0;
    di        = '0;
    out_group = '0;
    out_last  = 1'b0;
    if (out_valid) begin
      ar        = tap[rd_bank][0].re;
      br        = tap[rd_bank][1].re;
      cr        = tap[rd_bank][2].re;
      dr        = tap[rd_bank][3].re;
      ai        = tap[rd_bank][0].im;
      bi        = tap[rd_bank][1].im;
      ci        = tap[rd_bank][2].im;
      di        = tap[rd_bank][3].im;
      out_group = rd_grp;
      out_last  = (rd_grp == GW'(GROUPS - 1));
    end
  end

endmodule

// File: tb/tb_fft_input_reorder.sv
// Directed bench for fft_input_reorder: table-driven group checks plus
// hand-written backpressure, continuous, framing-error and reset sequences.
module tb_fft_input_reorder;

  typedef struct {
    logic [1:0]         grp;
    logic               last;
    logic signed [15:0] ar, br, cr, dr;
    logic signed [15:0] ai, bi, ci, di;
  } gvec_t;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] in_re;
  logic signed [15:0] in_im;
  logic               in_last;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] ar, br, cr, dr, ai, bi, ci, di;
  logic [1:0]         out_group;
  logic               out_last;
  logic               frame_err;

  int checks = 0;
  int errors = 0;
  int stalls = 0;

  gvec_t ramp_tbl [4];
  gvec_t ext_tbl  [4];

  fft_input_reorder #(.DW(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_re     (in_re),
    .in_im     (in_im),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ar        (ar),
    .br        (br),
    .cr        (cr),
    .dr        (dr),
    .ai        (ai),
    .bi        (bi),
    .ci        (ci),
    .di        (di),
    .out_group (out_group),
    .out_last  (out_last),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic gvec_t mkv(input int g, input bit last, input int a, input int b,
                                input int c, input int d, input int ia, input int ib,
                                input int ic, input int id);
    gvec_t v;
    v.grp  = 2'(g);
    v.last = last;
    v.ar = 16'(a);  v.br = 16'(b);  v.cr = 16'(c);  v.dr = 16'(d);
    v.ai = 16'(ia); v.bi = 16'(ib); v.ci = 16'(ic); v.di = 16'(id);
    return v;
  endfunction

  // Sample k of a ramp frame is (base+k, -(base+k)); group g takes x[g], x[g+4], x[g+8], x[g+12].
  function automatic gvec_t mk_ramp(input int base, input int g);
    return mkv(g, g == 3, base + g, base + g + 4, base + g + 8, base + g + 12,
               -(base + g), -(base + g + 4), -(base + g + 8), -(base + g + 12));
  endfunction

  // Drives one sample and returns #1 after the edge that accepted it.
  task automatic send(input int re, input int im, input logic last);
    bit   done;
    logic rdy;
    done     = 1'b0;
    in_re    = 16'(re);
    in_im    = 16'(im);
    in_last  = last;
    in_valid = 1'b1;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      if (rdy) done = 1'b1;
      else stalls++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("send_accepted", 16'(done), 16'd1);
  endtask

  // Waits for a valid group, compares it, and returns on the transfer edge (out_ready must be 1).
  task automatic check_group(input gvec_t v, input string tag);
    bit got;
    got = 1'b0;
    for (int n = 0; n < 100 && !got; n++) begin
      @(negedge clk);
      if (out_valid) begin
        got = 1'b1;
        chk({tag, "_grp"},  16'(out_group), 16'(v.grp));
        chk({tag, "_last"}, 16'(out_last),  16'(v.last));
        chk({tag, "_ar"}, ar, v.ar);
        chk({tag, "_br"}, br, v.br);
        chk({tag, "_cr"}, cr, v.cr);
        chk({tag, "_dr"}, dr, v.dr);
        chk({tag, "_ai"}, ai, v.ai);
        chk({tag, "_bi"}, bi, v.bi);
        chk({tag, "_ci"}, ci, v.ci);
        chk({tag, "_di"}, di, v.di);
      end
    end
    chk({tag, "_seen"}, 16'(got), 16'd1);
    if (got) @(posedge clk);
  endtask

  initial begin
    ramp_tbl[0] = mkv(0, 1'b0, 0, 4,  8, 12,  0, -4,  -8, -12);
    ramp_tbl[1] = mkv(1, 1'b0, 1, 5,  9, 13, -1, -5,  -9, -13);
    ramp_tbl[2] = mkv(2, 1'b0, 2, 6, 10, 14, -2, -6, -10, -14);
    ramp_tbl[3] = mkv(3, 1'b1, 3, 7, 11, 15, -3, -7, -11, -15);
    ext_tbl[0]  = mkv(0, 1'b0,  32767,  32767,  32767,  32767, -32768, -32768, -32768, -32768);
    ext_tbl[1]  = mkv(1, 1'b0, -32768, -32768, -32768, -32768,  32767,  32767,  32767,  32767);
    ext_tbl[2]  = mkv(2, 1'b0,  32767,  32767,  32767,  32767, -32768, -32768, -32768, -32768);
    ext_tbl[3]  = mkv(3, 1'b1, -32768, -32768, -32768, -32768,  32767,  32767,  32767,  32767);

    rst = 1'b1; in_valid = 1'b0; in_re = '0; in_im = '0; in_last = 1'b0; out_ready = 1'b0;

    // Reset state
    #12;
    chk("rst_in_ready", 16'(in_ready), 16'd0);
    chk("rst_out_valid", 16'(out_valid), 16'd0);
    chk("rst_frame_err", 16'(frame_err), 16'd0);
    chk("rst_ar", ar, 16'd0);
    #10 rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_in_ready", 16'(in_ready), 16'd1);

    // Single frame, with first-output latency
    out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      send(k, -k, k == 15);
      if (k == 14) chk("lat_valid_before", 16'(out_valid), 16'd0);
      if (k == 15) chk("lat_valid_after", 16'(out_valid), 16'd1);
    end
    for (int g = 0; g < 4; g++) check_group(ramp_tbl[g], "single");

    // Backpressure: two frames fill both banks
    #1 out_ready = 1'b0;
    for (int k = 0; k < 32; k++) send(1000 + (k / 16) * 1000 + (k % 16), -(1000 + (k / 16) * 1000 + (k % 16)), (k % 16) == 15);
    in_valid = 1'b1; in_re = 16'h7abc; in_im = 16'h1234;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk("bp_in_ready", 16'(in_ready), 16'd0);
      chk("bp_out_valid", 16'(out_valid), 16'd1);
      chk("bp_hold_grp", 16'(out_group), 16'd0);
      chk("bp_hold_ar", ar, 16'd1000);
      chk("bp_hold_di", di, -16'sd1012);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    for (int g = 0; g < 3; g++) check_group(mk_ramp(1000, g), "bp_f1");
    #1 chk("bp_in_ready_g3", 16'(in_ready), 16'd0);
    check_group(mk_ramp(1000, 3), "bp_f1");
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk("bp_in_ready_freed", 16'(in_ready), 16'd1);
    @(posedge clk); #1 out_ready = 1'b1;
    for (int g = 0; g < 4; g++) check_group(mk_ramp(2000, g), "bp_f2");

    // Continuous: 3 frames with both sides streaming
    #1 stalls = 0;
    fork
      for (int k = 0; k < 48; k++) send(3000 + (k / 16) * 100 + (k % 16), -(3000 + (k / 16) * 100 + (k % 16)), (k % 16) == 15);
      for (int f = 0; f < 3; f++)
        for (int g = 0; g < 4; g++) check_group(mk_ramp(3000 + f * 100, g), "cont");
    join
    chk("cont_no_stall", 16'(stalls), 16'd0);

    // Framing error: in_last on sample 9 instead of 15
    #1 out_ready = 1'b0;
    for (int k = 0; k < 16; k++) begin
      send(4000 + k, -(4000 + k), k == 9);
      if (k == 8) chk("ferr_before", 16'(frame_err), 16'd0);
      if (k == 9) chk("ferr_set", 16'(frame_err), 16'd1);
    end
    out_ready = 1'b1;
    for (int g = 0; g < 4; g++) check_group(mk_ramp(4000, g), "ferr");
    #1 chk("ferr_sticky", 16'(frame_err), 16'd1);

    // Reset with one full frame and a 7-sample partial frame buffered
    out_ready = 1'b0;
    for (int k = 0; k < 23; k++) send(500 + k, -(500 + k), k == 15);
    chk("pre_rst_valid", 16'(out_valid), 16'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", 16'(out_valid), 16'd0);
    chk("arst_ar", ar, 16'd0);
    chk("arst_di", di, 16'd0);
    chk("arst_in_ready", 16'(in_ready), 16'd0);
    chk("arst_frame_err", 16'(frame_err), 16'd0);
    @(negedge clk);
    chk("rst_hold_in_ready", 16'(in_ready), 16'd0);
    @(posedge clk); #3 rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 16'(in_ready), 16'd1);
    chk("post_rst_out_valid", 16'(out_valid), 16'd0);

    // Extreme values through a fresh frame
    out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      if (k % 2 == 0) send(32767, -32768, k == 15);
      else            send(-32768, 32767, k == 15);
    end
    for (int g = 0; g < 4; g++) check_group(ext_tbl[g], "ext");
    #1 chk("ext_frame_err", 16'(frame_err), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
